gather: RTL and testbench
=========================

GATHER -- requirements
Module: gather

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, element width in bits (FP16).
REQ-002 SHALL have parameter IN_SIZE, default 4, columns per row.
REQ-003 SHALL have parameter IN_PARALLELISM, default 1, rows per beat.
REQ-004 SHALL have parameter OUT_LARGE_COLUMNS, default 2, large columns per row (L).
REQ-005 SHALL have parameter OUT_SMALL_COLUMNS, default IN_SIZE-OUT_LARGE_COLUMNS, small columns per row (S).
REQ-006 SHALL have parameter IN_DEPTH, default 4, beats per tile.
REQ-007 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port data_in_large  input  IN_WIDTH x (L*IN_PARALLELISM)  large-column elements, row-major.
REQ-010 SHALL have ports data_in_large_valid input 1 and data_in_large_ready output 1.
REQ-011 SHALL have port data_in_small  input  IN_WIDTH x (S*IN_PARALLELISM)  small-column elements, row-major.
REQ-012 SHALL have ports data_in_small_valid input 1 and data_in_small_ready output 1.
REQ-013 SHALL have port ind_table  input  1 x IN_SIZE  per-column flag, 1 = large, 0 = small.
REQ-014 SHALL have port data_out  output  IN_WIDTH x (IN_SIZE*IN_PARALLELISM)  reassembled rows, index r*IN_SIZE+c.
REQ-015 SHALL have ports data_out_valid output 1 and data_out_ready input 1.
REQ-016 SHALL have port tile_last  output  1  qualifies data_out as last beat of a tile.
REQ-017 SHALL have port ind_error  output  1  sticky flag, latched table popcount != L.

Function
REQ-018 SHALL accept a beat only on cycles where both input valids are high and the output slot is free (data_out_valid low, or data_out_ready high); both inputs transfer together (join).
REQ-019 SHALL drive data_in_large_ready = data_in_small_ready = rst high AND slot free; neither ready depends on either input valid.
REQ-020 SHALL register the accepted beat into data_out, with data_out_valid high on the next cycle (latency 1); sustained throughput one beat per cycle.
REQ-021 SHALL hold data_out, tile_last and data_out_valid stable while data_out_valid is high and data_out_ready is low.
REQ-022 SHALL keep a beat counter 0..IN_DEPTH-1, incremented per accepted beat, wrapping IN_DEPTH-1 -> 0.
REQ-023 SHALL, when a beat is accepted with counter 0, latch ind_table into ind_q and use the live ind_table for that beat; beats 1..IN_DEPTH-1 use ind_q, ignoring ind_table changes.
REQ-024 SHALL map, per row r and column c: if flag[c]=1, data_out[r*IN_SIZE+c] = data_in_large[r*L+k], k = count of ones in flag[0..c-1]; else data_in_small[r*S+j], j = count of zeros in flag[0..c-1].
REQ-025 SHALL output zero for any element whose k >= L or j >= S (malformed table), never indexing out of range.
REQ-026 SHALL set tile_last high with the output beat that was accepted at counter IN_DEPTH-1, low otherwise.
REQ-027 SHALL set ind_error when a table latched at counter 0 has popcount != L; it stays set until reset.
REQ-028 SHALL, when IN_DEPTH = 1, latch and use ind_table every beat with tile_last high on every beat.

Reset
REQ-029 SHALL, while rst is low, force data_out_valid=0, tile_last=0, ind_error=0, all data_out elements=0, counter=0, ind_q=0, both readies=0.
REQ-030 SHALL, on reset assertion mid-tile, discard any pending output beat and restart at counter 0 after release.

Verification
REQ-031 SHALL be verified by: defaults, ind_table=0110, large={0x1111,0x2222}, small={0xAAAA,0xBBBB}, both valid -> next cycle data_out={0xAAAA,0x1111,0x2222,0xBBBB}, valid=1.
REQ-032 SHALL be verified by: data_out_ready held low 5 cycles with inputs valid -> readies low, data_out unchanged; ready raised -> next beat appears following cycle.
REQ-033 SHALL be verified by: only data_in_large_valid high for 3 cycles -> no transfer, data_out_valid stays 0, then small valid high -> one beat out.
REQ-034 SHALL be verified by: 8 back-to-back beats, ind_table changed to 1001 at beat 2 -> beats 0-3 use 0110, beats 4-7 use 1001; tile_last high on beats 3 and 7 only.
REQ-035 SHALL be verified by: ind_table=0111 at tile start -> ind_error=1 and stays 1; element needing k=2 outputs 0x0000.
REQ-036 SHALL be verified by: rst low mid-tile with data_out_valid high -> data_out_valid=0, ind_error=0 immediately; after release next beat is counter 0.

Source files
------------

// File: rtl/gather.sv
// gather: joins the large and small column streams and reassembles full rows,
// placing columns according to a column-type table latched once per tile.
module gather #(
  parameter int IN_WIDTH          = 16,
  parameter int IN_SIZE           = 4,
  parameter int IN_PARALLELISM    = 1,
  parameter int OUT_LARGE_COLUMNS = 2,
  parameter int OUT_SMALL_COLUMNS = IN_SIZE - OUT_LARGE_COLUMNS,
  parameter int IN_DEPTH          = 4
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic [OUT_LARGE_COLUMNS*IN_PARALLELISM-1:0][IN_WIDTH-1:0] data_in_large,
  input  logic                                                     data_in_large_valid,
  output logic                                                     data_in_large_ready,
  input  logic [OUT_SMALL_COLUMNS*IN_PARALLELISM-1:0][IN_WIDTH-1:0] data_in_small,
  input  logic                                                     data_in_small_valid,
  output logic                                                     data_in_small_ready,
  input  logic [IN_SIZE-1:0]                                       ind_table,
  output logic [IN_SIZE*IN_PARALLELISM-1:0][IN_WIDTH-1:0]           data_out,
  output logic                                                     data_out_valid,
  input  logic                                                     data_out_ready,
  output logic                                                     tile_last,
  output logic                                                     ind_error
);
  localparam int L  = OUT_LARGE_COLUMNS;
  localparam int S  = OUT_SMALL_COLUMNS;
  localparam int CW = IN_DEPTH > 1 ? $clog2(IN_DEPTH) : 1;
  logic [CW-1:0] cnt;
  logic [IN_SIZE-1:0] ind_q, flag;
  logic [IN_SIZE*IN_PARALLELISM-1:0][IN_WIDTH-1:0] row_out;
  logic first, last, acc;
  int k, j, ks, js;
  assign first = cnt == '0;
  assign last = cnt == CW'(IN_DEPTH - 1);
  assign data_in_large_ready = rst & (!data_out_valid | data_out_ready);
  assign data_in_small_ready = data_in_large_ready;
  assign acc = data_in_large_ready & data_in_large_valid & data_in_small_valid;
  assign flag = first ? ind_table : ind_q;
  // k/j are running counts of large/small columns to the left; clamped copies keep selects in range
  always_comb begin
    row_out = '0;
    k = 0;
    j = 0;
    ks = 0;
    js = 0;
    for (int c = 0; c < IN_SIZE; c++) begin
      ks = k < L ? k : 0;
      js = j < S ? j : 0;
      for (int r = 0; r < IN_PARALLELISM; r++)
        row_out[r*IN_SIZE+c] = flag[c] ? (k < L ? data_in_large[r*L+ks] : '0)
                                       : (j < S ? data_in_small[r*S+js] : '0);
      k = k + int'(flag[c]);
      j = j + int'(!flag[c]);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      tile_last      <= 1'b0;
      ind_error      <= 1'b0;
      cnt            <= '0;
      ind_q          <= '0;
    end else begin
      data_out_valid <= acc | (data_out_valid & !data_out_ready);
      if (acc) begin
        data_out  <= row_out;
        tile_last <= last;
        cnt       <= last ? '0 : cnt + 1'b1;
      end
      if (acc && first) begin
        ind_q     <= ind_table;
        ind_error <= ind_error | ($countones(ind_table) != L);
      end
    end
  end
endmodule

// File: tb/tb_gather.sv
// tb_gather: directed scenario tests for gather with hand-computed expected rows.
module tb_gather;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0][15:0] data_in_large;
  logic [1:0][15:0] data_in_small;
  logic data_in_large_valid = 1'b0, data_in_small_valid = 1'b0;
  logic data_in_large_ready, data_in_small_ready;
  logic [3:0] ind_table = 4'b0110;
  logic [3:0][15:0] data_out;
  logic data_out_valid, tile_last, ind_error;
  logic data_out_ready = 1'b1;
  logic [3:0][15:0] exp_out;
  int checks = 0;
  int errors = 0;

  gather dut (
    .clk(clk), .rst(rst),
    .data_in_large(data_in_large), .data_in_large_valid(data_in_large_valid),
    .data_in_large_ready(data_in_large_ready),
    .data_in_small(data_in_small), .data_in_small_valid(data_in_small_valid),
    .data_in_small_ready(data_in_small_ready),
    .ind_table(ind_table),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .tile_last(tile_last), .ind_error(ind_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [15:0] l0, l1, s0, s1);
    data_in_large[0] = l0;
    data_in_large[1] = l1;
    data_in_small[0] = s0;
    data_in_small[1] = s1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    data_in_large_valid = 1'b0;
    data_in_small_valid = 1'b0;
    data_out_ready = 1'b1;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    set_data(16'h0, 16'h0, 16'h0, 16'h0);
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({data_out_valid, tile_last, ind_error, data_in_large_ready, data_in_small_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got v=%b tl=%b err=%b rl=%b rs=%b, expected all 0",
               data_out_valid, tile_last, ind_error, data_in_large_ready, data_in_small_ready);
    end
    checks++;
    if (data_out !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", data_out);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({data_in_large_ready, data_in_small_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 11", {data_in_large_ready, data_in_small_ready});
    end
  endtask

  task automatic test_basic();
    do_reset();
    ind_table = 4'b0110;
    set_data(16'h1111, 16'h2222, 16'hAAAA, 16'hBBBB);
    data_in_large_valid = 1'b1;
    data_in_small_valid = 1'b1;
    step();
    exp_out = {16'hBBBB, 16'h2222, 16'h1111, 16'hAAAA};
    checks++;
    if (data_out !== exp_out || data_out_valid !== 1'b1 || tile_last !== 1'b0) begin
      errors++;
      $display("FAIL basic: got %h v=%b tl=%b expected %h v=1 tl=0", data_out, data_out_valid, tile_last, exp_out);
    end
    data_in_large_valid = 1'b0;
    data_in_small_valid = 1'b0;
    step();
    checks++;
    if (data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: got v=%b expected 0", data_out_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ind_table = 4'b0110;
    data_out_ready = 1'b0;
    set_data(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    data_in_large_valid = 1'b1;
    data_in_small_valid = 1'b1;
    step();
    exp_out = {16'h0404, 16'h0202, 16'h0101, 16'h0303};
    set_data(16'h0505, 16'h0606, 16'h0707, 16'h0808);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (data_out !== exp_out || data_out_valid !== 1'b1 ||
          data_in_large_ready !== 1'b0 || data_in_small_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got %h v=%b rl=%b rs=%b expected %h v=1 rl=0 rs=0",
                 i, data_out, data_out_valid, data_in_large_ready, data_in_small_ready, exp_out);
      end
      step();
    end
    data_out_ready = 1'b1;
    #1;
    checks++;
    if ({data_in_large_ready, data_in_small_ready} !== 2'b11) begin
      errors++;
      $display("FAIL backpressure_ready: got %b expected 11", {data_in_large_ready, data_in_small_ready});
    end
    step();
    exp_out = {16'h0808, 16'h0606, 16'h0505, 16'h0707};
    checks++;
    if (data_out !== exp_out || data_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_next: got %h v=%b expected %h v=1", data_out, data_out_valid, exp_out);
    end
    data_in_large_valid = 1'b0;
    data_in_small_valid = 1'b0;
    step();
  endtask

  task automatic test_join();
    do_reset();
    ind_table = 4'b0110;
    set_data(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    data_in_large_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (data_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL join_wait[%0d]: got v=%b expected 0", i, data_out_valid);
      end
    end
    data_in_small_valid = 1'b1;
    step();
    exp_out = {16'hDEF0, 16'h5678, 16'h1234, 16'h9ABC};
    checks++;
    if (data_out !== exp_out || data_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL join_beat: got %h v=%b expected %h v=1", data_out, data_out_valid, exp_out);
    end
    data_in_large_valid = 1'b0;
    data_in_small_valid = 1'b0;
    step();
    checks++;
    if (data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL join_single: got v=%b expected 0", data_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] l0, l1, s0, s1;
    do_reset();
    ind_table = 4'b0110;
    data_in_large_valid = 1'b1;
    data_in_small_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      l0 = 16'h1000 + 16'(i);
      l1 = 16'h2000 + 16'(i);
      s0 = 16'hA000 + 16'(i);
      s1 = 16'hB000 + 16'(i);
      set_data(l0, l1, s0, s1);
      if (i == 2) ind_table = 4'b1001;
      step();
      exp_out = i < 4 ? {s1, l1, l0, s0} : {l1, s1, s0, l0};
      checks++;
      if (data_out !== exp_out || data_out_valid !== 1'b1 || tile_last !== (i == 3 || i == 7)) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h v=%b tl=%b expected %h v=1 tl=%b",
                 i, data_out, data_out_valid, tile_last, exp_out, (i == 3 || i == 7));
      end
    end
    checks++;
    if (ind_error !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ind_error: got %b expected 0", ind_error);
    end
    data_in_large_valid = 1'b0;
    data_in_small_valid = 1'b0;
    step();
  endtask

  task automatic test_ind_error();
    do_reset();
    ind_table = 4'b0111;
    set_data(16'h1111, 16'h2222, 16'hAAAA, 16'hBBBB);
    data_in_large_valid = 1'b1;
    data_in_small_valid = 1'b1;
    step();
    exp_out = {16'hAAAA, 16'h0000, 16'h2222, 16'h1111};
    checks++;
    if (data_out !== exp_out || ind_error !== 1'b1) begin
      errors++;
      $display("FAIL ind_error_first: got %h err=%b expected %h err=1", data_out, ind_error, exp_out);
    end
    ind_table = 4'b0110;
    set_data(16'h3333, 16'h4444, 16'hCCCC, 16'hDDDD);
    step();
    exp_out = {16'hCCCC, 16'h0000, 16'h4444, 16'h3333};
    checks++;
    if (data_out !== exp_out || ind_error !== 1'b1) begin
      errors++;
      $display("FAIL ind_error_latched: got %h err=%b expected %h err=1", data_out, ind_error, exp_out);
    end
    step();
    step();
    step();
    exp_out = {16'hDDDD, 16'h4444, 16'h3333, 16'hCCCC};
    checks++;
    if (data_out !== exp_out || ind_error !== 1'b1) begin
      errors++;
      $display("FAIL ind_error_sticky: got %h err=%b expected %h err=1", data_out, ind_error, exp_out);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b0;
    #1;
    checks++;
    if ({data_out_valid, ind_error, tile_last, data_in_large_ready, data_in_small_ready} !== 5'b0 ||
        data_out !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b err=%b tl=%b rl=%b rs=%b d=%h expected all 0",
               data_out_valid, ind_error, tile_last, data_in_large_ready, data_in_small_ready, data_out);
    end
    step();
    rst = 1'b1;
    ind_table = 4'b1001;
    set_data(16'h1111, 16'h2222, 16'hAAAA, 16'hBBBB);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) ind_table = 4'b0110;
      exp_out = {16'h2222, 16'hBBBB, 16'hAAAA, 16'h1111};
      checks++;
      if (data_out !== exp_out || data_out_valid !== 1'b1 || tile_last !== (i == 3) || ind_error !== 1'b0) begin
        errors++;
        $display("FAIL reset_restart[%0d]: got %h v=%b tl=%b err=%b expected %h v=1 tl=%b err=0",
                 i, data_out, data_out_valid, tile_last, ind_error, exp_out, (i == 3));
      end
    end
    data_in_large_valid = 1'b0;
    data_in_small_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_join();
    test_back_to_back();
    test_ind_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
